// File: rtl/fifo_mem_param.sv
// Synchronous FIFO, depth 2**ADDR_W, with occupancy count and programmable almost-full/almost-empty flags.
// Define FIFO_ERR_EN to add a sticky err output for dropped writes and ignored reads.
module fifo_mem_param #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] af_thresh,
  input  logic [ADDR_W-1:0] ae_thresh,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fill_level
`ifdef FIFO_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   fill_next;
  logic              rd_acc;
  logic              wr_acc;

  // A write into a full FIFO is only allowed when a read frees a slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    fill_next = fill_level;
    case ({wr_acc, rd_acc})
      2'b10:   fill_next = fill_level + 1'b1;
      2'b01:   fill_next = fill_level - 1'b1;
      default: fill_next = fill_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      full       <= 1'b0;
      empty      <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      valid_out  <= rd_acc;
      fill_level <= fill_next;
      full       <= (fill_next == DEPTH_L);
      empty      <= (fill_next == '0);
    end
  end

  assign almost_full  = (fill_level >= {1'b0, af_thresh});
  assign almost_empty = (fill_level <= {1'b0, ae_thresh});

`ifdef FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((wr_en & full & ~rd_acc) | (rd_en & empty)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_mem_param.sv
// Randomised self-checking bench for fifo_mem_param against a queue-based reference model.
module tb_fifo_mem_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        rd_en;
  logic [9:0]  data_in;
  logic [3:0]  af_thresh;
  logic [3:0]  ae_thresh;
  logic [9:0]  data_out;
  logic        valid_out;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  fill_level;
`ifdef FIFO_ERR_EN
  logic        err;
`endif

  fifo_mem_param #(.DATA_W(10), .ADDR_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .data_in      (data_in),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fill_level   (fill_level)
`ifdef FIFO_ERR_EN
    ,
    .err          (err)
`endif
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [9:0] q[$];
  logic [9:0] exp_dout;
  logic       exp_valid;
  logic       m_err;

  wire [19:0] obs = {fill_level, full, empty, almost_full, almost_empty, valid_out, data_out};

  function automatic logic [19:0] expect_vec();
    int n = q.size();
    return {5'(n), n == 16, n == 0, n >= int'(af_thresh), n <= int'(ae_thresh), exp_valid, exp_dout};
  endfunction

  // Drives one cycle of requests and advances the reference model from pre-edge occupancy.
  task automatic step(input logic wr, input logic rd, input logic [9:0] din);
    logic ra, wa;
    @(negedge clk);
    wr_en = wr; rd_en = rd; data_in = din;
    ra = rd && q.size() != 0;
    wa = wr && (q.size() != 16 || ra);
    if ((wr && q.size() == 16 && !ra) || (rd && q.size() == 0)) m_err = 1'b1;
    exp_valid = ra;
    if (ra) exp_dout = q.pop_front();
    if (wa) q.push_back(din);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 10'($urandom);
    @(posedge clk); #1;
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    q.delete(); exp_dout = '0; exp_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (obs !== expect_vec()) begin
      n_err++; $display("FAIL reset_state act=%h req=%h", obs, expect_vec());
    end
    af_thresh = 4'd0; #1;
    n_vec++;
    if (almost_full !== 1'b1) begin
      n_err++; $display("FAIL reset_af_zero act=%b req=1", almost_full);
    end
    af_thresh = 4'd14; #1;
`ifdef FIFO_ERR_EN
    n_vec++;
    if (err !== 1'b0) begin
      n_err++; $display("FAIL reset_err act=%b req=0", err);
    end
`endif
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 10'(i));
      n_vec++;
      if (obs !== expect_vec()) begin
        n_err++; $display("FAIL fill_%0d act=%h req=%h", i, obs, expect_vec());
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 10'($urandom));
      n_vec++;
      if (obs !== expect_vec()) begin
        n_err++; $display("FAIL drain_%0d act=%h req=%h", i, obs, expect_vec());
      end
    end
  endtask

  task automatic test_full_boundaries();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 10'($urandom_range(1, 1022)));
    step(1'b1, 1'b0, 10'h3FF);
    n_vec++;
    if (obs !== expect_vec()) begin
      n_err++; $display("FAIL full_drop act=%h req=%h", obs, expect_vec());
    end
`ifdef FIFO_ERR_EN
    n_vec++;
    if (err !== 1'b1) begin
      n_err++; $display("FAIL full_drop_err act=%b req=1", err);
    end
`endif
    step(1'b1, 1'b1, 10'h155);
    n_vec++;
    if (obs !== expect_vec()) begin
      n_err++; $display("FAIL full_rdwr act=%h req=%h", obs, expect_vec());
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 10'h0);
      n_vec++;
      if (obs !== expect_vec() || data_out === 10'h3FF) begin
        n_err++; $display("FAIL full_drain_%0d act=%h req=%h", i, obs, expect_vec());
      end
    end
  endtask

  task automatic test_empty_boundaries();
    apply_reset();
    step(1'b0, 1'b1, 10'h0);
    n_vec++;
    if (obs !== expect_vec()) begin
      n_err++; $display("FAIL empty_rd act=%h req=%h", obs, expect_vec());
    end
`ifdef FIFO_ERR_EN
    n_vec++;
    if (err !== 1'b1) begin
      n_err++; $display("FAIL empty_rd_err act=%b req=1", err);
    end
`endif
    step(1'b1, 1'b1, 10'h0AA);
    n_vec++;
    if (obs !== expect_vec()) begin
      n_err++; $display("FAIL empty_rdwr act=%h req=%h", obs, expect_vec());
    end
    step(1'b1, 1'b1, 10'h0BB);
    n_vec++;
    if (obs !== expect_vec()) begin
      n_err++; $display("FAIL single_rdwr act=%h req=%h", obs, expect_vec());
    end
    step(1'b0, 1'b1, 10'h0);
    n_vec++;
    if (obs !== expect_vec()) begin
      n_err++; $display("FAIL single_drain act=%h req=%h", obs, expect_vec());
    end
  endtask

  task automatic test_random();
    int wr_bias;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) wr_bias = (i / 50) % 2 ? 25 : 75;
      if (i % 64 == 0) begin
        @(negedge clk);
        af_thresh = 4'($urandom); ae_thresh = 4'($urandom);
      end
      step($urandom_range(0, 99) < wr_bias, $urandom_range(0, 99) < 100 - wr_bias,
           10'($urandom));
      n_vec++;
      if (obs !== expect_vec()) begin
        n_err++; $display("FAIL random_%0d act=%h req=%h", i, obs, expect_vec());
      end
`ifdef FIFO_ERR_EN
      n_vec++;
      if (err !== m_err) begin
        n_err++; $display("FAIL random_err_%0d act=%b req=%b", i, err, m_err);
      end
`endif
    end
    @(negedge clk);
    af_thresh = 4'd14; ae_thresh = 4'd2;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 10'($urandom_range(1, 1023)));
    step(1'b0, 1'b1, 10'h0);
    step(1'b1, 1'b0, 10'h2A5);
    n_vec++;
    if (fill_level !== 5'd9 || data_out === 10'h0) begin
      n_err++; $display("FAIL pre_reset act=%h req_fill=9", obs);
    end
    apply_reset();
    n_vec++;
    if (obs !== expect_vec()) begin
      n_err++; $display("FAIL mid_reset act=%h req=%h", obs, expect_vec());
    end
`ifdef FIFO_ERR_EN
    n_vec++;
    if (err !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_err act=%b req=0", err);
    end
`endif
    step(1'b1, 1'b0, 10'h123);
    step(1'b0, 1'b1, 10'h0);
    n_vec++;
    if (obs !== expect_vec()) begin
      n_err++; $display("FAIL post_reset act=%h req=%h", obs, expect_vec());
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    af_thresh = 4'd14; ae_thresh = 4'd2;
    exp_dout = '0; exp_valid = 1'b0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_full_boundaries();
    test_empty_boundaries();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
